// File: rtl/aes_inv_mix_columns_seq.sv
// aes_inv_mix_columns_seq: iterative AES InvMixColumns engine.
// Accepts a 128-bit state and transforms one 32-bit column per clock over
// four RUN cycles, then presents the result until the consumer takes it.
// Byte (row r, column c) of data_i/data_o sits at bits [((r*4)+c)*8 +: 8].
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready_o and out_valid_o are decoded from the state register
// only, so neither depends combinationally on any input.
//
// Optional feature: define AES_INV_MIX_SELFCHECK_EN to re-apply forward
// MixColumns to every computed column and raise a sticky err_o on mismatch.
// Without it err_o is tied low and no check logic exists.
module aes_inv_mix_columns_seq (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // state_q is the FSM state register; bind checkers to it directly.
  state_t       state_q;
  state_t       state_d;
  logic [1:0]   col_q;
  logic [127:0] in_q;
  logic [127:0] res_q;
  logic [31:0]  src_col;
  logic [31:0]  inv_col_w;

  // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multiplies assembled from the x2/x4/x8 chain.
  function automatic logic [7:0] mul_09(input logic [7:0] b);
    mul_09 = xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul_0b(input logic [7:0] b);
    mul_0b = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul_0d(input logic [7:0] b);
    mul_0d = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul_0e(input logic [7:0] b);
    mul_0e = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Column word: row 0 in bits [31:24], row 3 in bits [7:0].
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    inv_col = {mul_0e(b0) ^ mul_0b(b1) ^ mul_0d(b2) ^ mul_09(b3),
               mul_0e(b1) ^ mul_0b(b2) ^ mul_0d(b3) ^ mul_09(b0),
               mul_0e(b2) ^ mul_0b(b3) ^ mul_0d(b0) ^ mul_09(b1),
               mul_0e(b3) ^ mul_0b(b0) ^ mul_0d(b1) ^ mul_09(b2)};
  endfunction

  // Gather the four bytes of the current column from the input register.
  always_comb begin
    src_col   = {in_q[{2'd0, col_q, 3'd0} +: 8],
                 in_q[{2'd1, col_q, 3'd0} +: 8],
                 in_q[{2'd2, col_q, 3'd0} +: 8],
                 in_q[{2'd3, col_q, 3'd0} +: 8]};
    inv_col_w = inv_col(src_col);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on input handshake, one result column per RUN cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= 2'd0;
      in_q  <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            in_q  <= data_i;
            col_q <= 2'd0;
          end
        end
        RUN: begin
          res_q[{2'd0, col_q, 3'd0} +: 8] <= inv_col_w[31:24];
          res_q[{2'd1, col_q, 3'd0} +: 8] <= inv_col_w[23:16];
          res_q[{2'd2, col_q, 3'd0} +: 8] <= inv_col_w[15:8];
          res_q[{2'd3, col_q, 3'd0} +: 8] <= inv_col_w[7:0];
          col_q <= col_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign data_o = res_q;

`ifdef AES_INV_MIX_SELFCHECK_EN
  logic        err_q;
  logic [31:0] fwd_col_w;

  function automatic logic [7:0] mul_03(input logic [7:0] b);
    mul_03 = xtime(b) ^ b;
  endfunction

  // Forward MixColumns of the computed column must reproduce the source.
  always_comb begin
    fwd_col_w = {xtime(inv_col_w[31:24]) ^ mul_03(inv_col_w[23:16]) ^ inv_col_w[15:8] ^ inv_col_w[7:0],
                 inv_col_w[31:24] ^ xtime(inv_col_w[23:16]) ^ mul_03(inv_col_w[15:8]) ^ inv_col_w[7:0],
                 inv_col_w[31:24] ^ inv_col_w[23:16] ^ xtime(inv_col_w[15:8]) ^ mul_03(inv_col_w[7:0]),
                 mul_03(inv_col_w[31:24]) ^ inv_col_w[23:16] ^ inv_col_w[15:8] ^ xtime(inv_col_w[7:0])};
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                        err_q <= 1'b0;
    else if (state_q == RUN && fwd_col_w != src_col) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/aes_inv_mix_columns_seq.md
# aes_inv_mix_columns_seq

Iterative AES InvMixColumns engine for the decryption datapath. It accepts a full 128-bit AES state over a valid/ready handshake and processes one 32-bit column per clock. It returns the transformed state over a second valid/ready handshake. It sits between AddRoundKey and InvShiftRows/InvSubBytes in area-optimised cipher cores, replacing four parallel column units with one.

## Interface
Parameters: none.
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  input state valid.
- `in_ready_o`  out  1  engine can accept a state.
- `data_i`  in  128  input state. Byte (row r, column c) sits at bits [((r*4)+c)*8 +: 8].
- `out_valid_o`  out  1  result state valid.
- `out_ready_i`  in  1  downstream accepts the result.
- `data_o`  out  128  result state, same byte layout as `data_i`.
- `busy_o`  out  1  high in RUN or DONE.
- `err_o`  out  1  sticky self-check error (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - `in_ready_o`=1.
  - On `in_valid_i & in_ready_o`: latch `data_i` into the input register, clear column counter `col`=0, go to RUN.
- RUN
  - Each cycle, read column `col` (4 bytes b0..b3, row 0 = b0) from the input register.
  - Write the result bytes into the result register at column `col`:
    - b'r = 0e·br ^ 0b·b(r+1) ^ 0d·b(r+2) ^ 09·b(r+3), indices mod 4.
    - Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1.
  - The constant multiplies are built from the xtime chain (x2, x4, x8); the byte path has no carries.
  - `col` increments by 1 each cycle. After writing `col`=3, go to DONE. The 2-bit counter wraps to 0.
- DONE
  - `out_valid_o`=1.
  - `data_o` = result register, held stable until `out_valid_o & out_ready_i`; then go to IDLE.
- `in_ready_o`=0 in RUN and DONE. `in_valid_i` in those states is ignored, and `data_i` is not sampled.
- `data_o` retains the last result after the handshake. It is not a valid result until the next DONE.
- The result register updates only in RUN. Input register contents never change outside the IDLE handshake.

## Timing
- Reset values:
  - FSM = IDLE, `col`=0, input and result registers = 0.
  - `in_ready_o`=1, `out_valid_o`=0, `data_o`=0, `busy_o`=0, `err_o`=0.
- Latency: handshake accepted at edge E0 → RUN covers cycles 1–4 (columns 0–3) → `out_valid_o`=1 from cycle 5.
- Minimum initiation interval is 6 cycles: output handshake in cycle 5 returns the FSM to IDLE in cycle 6.
- `out_ready_i` low in DONE: stall indefinitely, all outputs stable.
- `out_ready_i` high before DONE has no effect.
- Reset asserted in any state aborts the operation on the next edge. No `out_valid_o` pulse follows, and partial results are cleared to 0.
- Simultaneous `rst_i` and a handshake: reset wins, and the handshake is dropped.
- All outputs are registered or decoded from FSM state only. There is no combinational path from any input to any output.

## Configuration
- Macro `AES_INV_MIX_SELFCHECK_EN`.
- Defined:
  - In each RUN cycle, the computed column is passed through the forward MixColumns (02/03/01/01) and compared with the source column.
  - On mismatch, `err_o` is set the following cycle and stays high until `rst_i`.
  - Adds one forward-mix column unit and a 32-bit comparator.
- Not defined: `err_o` is tied to 0 and no check logic is synthesised. Functional behaviour and timing are otherwise identical.

## Test plan
- Known column vectors:
  - Column 0 = 8e 4d a1 bc → column 0 out = db 13 53 45.
  - Column 1 = 9f dc 58 9d → f2 0a 22 5c.
  - Column 2 = d5 d5 d7 d6 → d4 d4 d4 d5.
  - Column 3 = c6 c6 c6 c6 → c6 c6 c6 c6.
  - `out_valid_o` rises exactly 5 cycles after acceptance; `err_o` stays 0 with the macro defined.
- All-zero state → all-zero result. All-01 state → all-01 result.
- Backpressure:
  - Hold `out_ready_i`=0 for 10 cycles in DONE: `data_o` and `out_valid_o` stable, `in_ready_o`=0.
  - Pulse `in_valid_i` with a different state during the stall: it is ignored and the result is unchanged.
- Back-to-back: two states with `in_valid_i` held high and `out_ready_i`=1. Second acceptance occurs in cycle 6, results come out in order, and the second `out_valid_o` appears at cycle 11.
- Reset mid-operation: assert `rst_i` in RUN at `col`=2.
  - Next cycle: IDLE, `in_ready_o`=1, `data_o`=0, no `out_valid_o`.
  - A fresh state then completes normally.
- Round-trip: random states through a reference forward MixColumns, then this block. Over ≥1000 states the output equals the original state and `err_o` remains 0.
